// File: rtl/hazard_ctrl_md_if.sv
// Decoded D/E/M pipeline fields in, stall controls out, for the hazard/MDU stall controller.
// The HAZARD_STAT_EN build adds the two stall statistics counters.
interface hazard_ctrl_md_if #(
    parameter int TW = 2
);
    logic [4:0]    D_rs;
    logic [4:0]    D_rt;
    logic [TW-1:0] Tuse_rs;
    logic [TW-1:0] Tuse_rt;
    logic          D_md_use;
    logic [4:0]    E_dst;
    logic [TW-1:0] Tnew_E;
    logic [4:0]    M_dst;
    logic [TW-1:0] Tnew_M;
    logic          E_md_start;
    logic          E_md_div;
    logic          stall;
    logic [2:0]    stall_cause;
    logic          md_busy;
    logic          md_err;
`ifdef HAZARD_STAT_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   md_stall_cycles;
`endif

    modport master (
        output D_rs, D_rt, Tuse_rs, Tuse_rt, D_md_use,
        output E_dst, Tnew_E, M_dst, Tnew_M, E_md_start, E_md_div,
`ifdef HAZARD_STAT_EN
        input  stall_cycles, md_stall_cycles,
`endif
        input  stall, stall_cause, md_busy, md_err
    );

    modport slave (
        input  D_rs, D_rt, Tuse_rs, Tuse_rt, D_md_use,
        input  E_dst, Tnew_E, M_dst, Tnew_M, E_md_start, E_md_div,
`ifdef HAZARD_STAT_EN
        output stall_cycles, md_stall_cycles,
`endif
        output stall, stall_cause, md_busy, md_err
    );
endinterface

// File: rtl/hazard_ctrl_md.sv
// Tuse/Tnew data-hazard stall plus multiply/divide busy tracker; stall is zero-latency combinational.
// Optional HAZARD_STAT_EN adds free-running stall_cycles / md_stall_cycles counters.
module hazard_ctrl_md #(
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_md_if.slave  hz
);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_err_q, md_err_d;
    logic             e_rs_hit, e_rt_hit, m_rs_hit, m_rt_hit;
    logic             md_idle;
    logic [2:0]       cause;

    // Register 0 is hardwired, so it never creates a dependency.
    assign e_rs_hit = (hz.D_rs != 5'd0) && (hz.D_rs == hz.E_dst) && (hz.Tnew_E > hz.Tuse_rs);
    assign e_rt_hit = (hz.D_rt != 5'd0) && (hz.D_rt == hz.E_dst) && (hz.Tnew_E > hz.Tuse_rt);
    assign m_rs_hit = (hz.D_rs != 5'd0) && (hz.D_rs == hz.M_dst) && (hz.Tnew_M > hz.Tuse_rs);
    assign m_rt_hit = (hz.D_rt != 5'd0) && (hz.D_rt == hz.M_dst) && (hz.Tnew_M > hz.Tuse_rt);

    assign md_idle = (md_cnt_q == '0);

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.E_md_start && md_idle) begin
            md_cnt_d = hz.E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (!md_idle) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // A start while busy is dropped; the sticky flag records the pipeline bug.
    assign md_err_d = md_err_q | (hz.E_md_start & ~md_idle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q <= '0;
            md_err_q <= 1'b0;
        end else begin
            md_cnt_q <= md_cnt_d;
            md_err_q <= md_err_d;
        end
    end

    assign hz.md_busy     = ~md_idle | hz.E_md_start;
    assign cause[0]       = e_rs_hit | e_rt_hit;
    assign cause[1]       = m_rs_hit | m_rt_hit;
    assign cause[2]       = hz.D_md_use & hz.md_busy;
    assign hz.stall_cause = cause;
    assign hz.stall       = |cause;
    assign hz.md_err      = md_err_q;

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] md_stall_cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            if (hz.stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (cause[2]) begin
                md_stall_cycles_q <= md_stall_cycles_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles    = stall_cycles_q;
    assign hz.md_stall_cycles = md_stall_cycles_q;
`endif

endmodule

// File: doc/hazard_ctrl_md.md
Name: hazard_ctrl_md

Overview:
- Parametrised hazard/stall controller for the 5-stage MIPS pipeline; successor to the combinational Tuse/Tnew stall unit.
- Adds configurable Tuse/Tnew width and a sequential multiply/divide busy tracker. Instructions that touch HI/LO stall in D while the MDU is occupied.
- Takes decoded D/E/M fields from the existing control decoders.
- Drives PC enable, D-register enable and E-register clear (bubble insert).

Parameters:
- TW, 2, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, MDU counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- D_rs  in  5  rs register read by the D instruction
- D_rt  in  5  rt register read by the D instruction
- Tuse_rs  in  TW  cycles until D needs rs
- Tuse_rt  in  TW  cycles until D needs rt
- D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_dst  in  5  destination register of the E instruction (0 = none)
- Tnew_E  in  TW  cycles until the E result is ready
- M_dst  in  5  destination register of the M instruction
- Tnew_M  in  TW  cycles until the M result is ready
- E_md_start  in  1  E instruction is mult/multu/div/divu (one-cycle pulse)
- E_md_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  freeze PC and D register; clear E register
- stall_cause  out  3  bit0 = E data hazard, bit1 = M data hazard, bit2 = MDU hazard
- md_busy  out  1  MDU occupied
- md_err  out  1  sticky: start received while busy

Behaviour:
- Data hazard, per source s in {rs, rt} and stage X in {E, M}: hit when D_s != 0 and D_s == X_dst and Tnew_X > Tuse_s.
  - Compare unsigned at TW bits.
  - stall_cause[0] = OR of both E hits; stall_cause[1] = OR of both M hits.
- MDU counter md_cnt (CNT_W bits), reset value 0.
  - E_md_start && md_cnt == 0: load DIV_CYCLES if E_md_div, else MULT_CYCLES.
  - Otherwise, md_cnt != 0: decrement by 1.
  - Otherwise: hold.
- md_busy = (md_cnt != 0) | E_md_start. Combinational, so it is valid in the start cycle.
- Busy window is the start cycle plus N following cycles, N+1 cycles total.
- stall_cause[2] = D_md_use & md_busy.
- stall = OR of all stall_cause bits. Purely combinational from inputs and md_cnt; zero-cycle latency.
- The counter advances independently of stall; stall never freezes the MDU.
- E_md_start while md_cnt != 0:
  - start is ignored and md_cnt keeps decrementing;
  - md_err sets on the next clk edge and holds until reset.
  - This cannot occur with correct stalling; it is a checker aid.
- Last busy cycle (md_cnt == 1): a D_md_use instruction still stalls. The next cycle (md_cnt == 0, no start) releases it.
- Register 0 is never a hazard, even when E_dst/M_dst == 0.
- Simultaneous E and M hits on the same register: both cause bits are set; stall = 1.
- Reset values: md_cnt = 0, md_err = 0.
  - While inputs are zero, stall = 0, stall_cause = 0 and md_busy = 0.
  - Reset asserted mid-count clears md_cnt immediately, without waiting for clk.

Optional Feature:
- Macro HAZARD_STAT_EN, when defined:
  - adds outputs stall_cycles [31:0] and md_stall_cycles [31:0];
  - stall_cycles increments on every clk edge where stall = 1; md_stall_cycles increments where stall_cause[2] = 1;
  - both wrap from 32'hFFFFFFFF to 0 and clear on reset.
- When not defined: the ports are absent and no counter logic exists. All other behaviour is identical.

Test Plan:
- E: lw to $8, Tnew_E = 2; D: beq reading $8 on rs, Tuse_rs = 0 -> stall = 1, stall_cause = 3'b001. Same case with D_rs = 0 and E_dst = 0 -> stall = 0.
- M: Tnew_M = 1, M_dst = $9; D: addu with rt = $9, Tuse_rt = 1 -> stall = 0. Change Tuse_rt to 0 -> stall = 1, stall_cause = 3'b010.
- E_md_start = 1, E_md_div = 0, with D_md_use held 1 -> md_busy and stall high for exactly 6 cycles (start cycle + 5), then 0. md_cnt sequence: 5, 4, 3, 2, 1, 0.
- Div start (E_md_div = 1) -> busy for 11 cycles. Second start pulse at cycle 4 -> ignored; busy still ends at cycle 11; md_err = 1 from cycle 5 onward.
- Reset pulse at md_cnt = 3, asserted between clk edges -> md_busy = 0 immediately; md_err = 0.
- With HAZARD_STAT_EN: the mult scenario above -> md_stall_cycles = 6, stall_cycles = 6. Preload near 32'hFFFFFFFF -> verify wrap to 0.
